// File: rtl/ascon_output_seq_if.sv
// Core-side output stream of the ASCON sequencer: control, datapath blocks,
// truncation unit loop and the registered valid/ready output beat.
interface ascon_output_seq_if #(
    parameter int BLOCK_WIDTH = 64,
    parameter int PAD_AW      = 3,
    parameter int LEN_W       = 16
);
    logic                     start;
    logic                     clear;
    logic [LEN_W-1:0]         len;
    logic                     busy;
    logic                     done;
    logic                     in_valid;
    logic [BLOCK_WIDTH-1:0]   in_data;
    logic                     in_ready;
    logic                     tr_en;
    logic [PAD_AW-1:0]        tr_idx;
    logic [BLOCK_WIDTH-1:0]   tr_data;
    logic [BLOCK_WIDTH-1:0]   tr_result;
    logic                     out_valid;
    logic [BLOCK_WIDTH-1:0]   out_data;
    logic [BLOCK_WIDTH/8-1:0] out_strb;
    logic                     out_last;
    logic                     out_ready;

    modport master (
        output start, clear, len, in_valid, in_data, tr_result, out_ready,
        input  busy, done, in_ready, tr_en, tr_idx, tr_data,
               out_valid, out_data, out_strb, out_last
    );

    modport slave (
        input  start, clear, len, in_valid, in_data, tr_result, out_ready,
        output busy, done, in_ready, tr_en, tr_idx, tr_data,
               out_valid, out_data, out_strb, out_last
    );
endinterface

// File: rtl/ascon_output_seq.sv
// Sequences ASCON output blocks over a byte length, driving truncation and a registered beat.
// Latency: input handshake -> out_valid one cycle later; full throughput of 1 beat/cycle.
// Backpressure: in_ready drops while the output register is held by out_ready low.
module ascon_output_seq #(
    parameter int BLOCK_WIDTH = 64,
    parameter int PAD_NO      = 8,
    parameter int PAD_AW      = 3,
    parameter int LEN_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ascon_output_seq_if.slave  bus
);
    localparam int BYTES = BLOCK_WIDTH / 8;
    localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);
    localparam logic [LEN_W-1:0] PAD_L   = LEN_W'(PAD_NO);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [LEN_W-1:0]       rem;
    logic                   out_valid;
    logic                   out_last;
    logic [BLOCK_WIDTH-1:0] out_data;
    logic [BYTES-1:0]       out_strb;

    logic                   in_ready;
    logic                   in_hs;
    logic                   out_hs;
    logic                   beat_last;
    logic                   tr_en;
    logic [BYTES-1:0]       strb_next;

    // Byte i is valid while more than i bytes remain; saturates to all-ones.
    always_comb begin
        strb_next = '0;
        for (int i = 0; i < BYTES; i++) begin
            strb_next[i] = (rem > LEN_W'(i));
        end
    end

    assign beat_last = (rem <= BYTES_L);
    assign in_ready  = (state == RUN) & (~out_valid | bus.out_ready);
    assign in_hs     = bus.in_valid & in_ready;
    assign out_hs    = out_valid & bus.out_ready;
    assign tr_en     = (state == RUN) && (rem < PAD_L);

    assign bus.in_ready  = in_ready;
    assign bus.tr_en     = tr_en;
    assign bus.tr_idx    = tr_en ? rem[PAD_AW-1:0] : '0;
    assign bus.tr_data   = bus.in_data;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_strb  = out_strb;
    assign bus.out_last  = out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_strb  <= '0;
        end else if (bus.clear) begin
            // Abort: any pending beat is dropped and no done pulse is produced.
            state     <= IDLE;
            rem       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem   <= bus.len;
                        state <= (bus.len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        out_data  <= bus.tr_result;
                        out_valid <= 1'b1;
                        out_last  <= beat_last;
                        out_strb  <= strb_next;
                        rem       <= beat_last ? '0 : rem - BYTES_L;
                        if (beat_last) begin
                            state <= DRAIN;
                        end
                    end else if (out_hs) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_output_seq.sv
// Directed bench for ascon_output_seq: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_ascon_output_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ascon_output_seq_if #(.BLOCK_WIDTH(64), .PAD_AW(3), .LEN_W(16)) bus ();

    ascon_output_seq #(
        .BLOCK_WIDTH(64), .PAD_NO(8), .PAD_AW(3), .LEN_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int in_ready_cnt = 0;
    int ready_mode = 0;
    int pat_i = 0;
    logic [3:0] pat = 4'b1001;

    logic        prev_stall = 1'b0;
    logic        prev_clear = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_strb;
    logic        prev_last;

    // Reference truncation unit: bytes at or above the pad index are zeroed.
    function automatic logic [63:0] trunc(logic [63:0] d, logic en, logic [2:0] idx);
        logic [63:0] r;
        r = d;
        for (int i = 0; i < 8; i++) begin
            if (en && i >= int'(idx)) r[i*8 +: 8] = 8'h00;
        end
        return r;
    endfunction

    assign bus.tr_result = trunc(bus.tr_data, bus.tr_en, bus.tr_idx);

    function automatic logic [7:0] exp_strb(int rem);
        if (rem >= 8) return 8'hFF;
        return 8'hFF >> (8 - rem);
    endfunction

    function automatic logic [63:0] mask_data(logic [63:0] d, logic [7:0] s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops, stall stability, done and in_ready activity.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.in_ready) in_ready_cnt++;
            if (bus.done) done_cnt++;
            if (prev_stall && !prev_clear) begin
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_strb", 64'(bus.out_strb), 64'(prev_strb));
                chk("stall_last", 64'(bus.out_last), 64'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h with no beat expected", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.out_data, e.data);
                    chk("beat_strb", 64'(bus.out_strb), 64'(e.strb));
                    chk("beat_last", 64'(bus.out_last), 64'(e.last));
                    beat_cnt++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_strb  = bus.out_strb;
            prev_last  = bus.out_last;
            prev_clear = bus.clear;
        end
    end

    // Downstream ready driver: 0 = always ready, 1 = stalled, 2 = 1-0-0-1 then random.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'b0;
                default: begin
                    bus.out_ready = (pat_i < 4) ? pat[pat_i] : 1'($urandom_range(0, 1));
                    pat_i++;
                end
            endcase
        end
    end

    // Offers one block; returns at posedge+1 after the handshake edge.
    task automatic send_block(input logic [63:0] d, input logic exp_en, input logic [2:0] exp_idx);
        bit hs = 0;
        int n = 0;
        logic en_s = 1'b0;
        logic [2:0] idx_s = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!hs && n < 200) begin
            @(negedge clk);
            if (bus.in_ready) begin
                hs = 1;
                en_s = bus.tr_en;
                idx_s = bus.tr_idx;
            end
            n++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL in_handshake: timeout after %0d cycles, required a handshake", n);
        end else begin
            chk("tr_en", 64'(en_s), 64'(exp_en));
            chk("tr_idx", 64'(idx_s), 64'(exp_idx));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 300);
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input int len);
        bus.start = 1'b1;
        bus.len   = 16'(len);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_and_send(input int len, input int k, input logic [63:0] blk);
        int rem;
        beat_t b;
        rem = len - 8 * k;
        b.strb = exp_strb(rem);
        b.data = mask_data(blk, b.strb);
        b.last = (rem <= 8);
        exp_q.push_back(b);
        send_block(blk, rem < 8, (rem < 8) ? 3'(rem) : 3'd0);
    endtask

    task automatic run_seq(input int len, input logic [63:0] base, input bit poke);
        int nb;
        int d0;
        int b0;
        nb = (len + 7) / 8;
        d0 = done_cnt;
        b0 = beat_cnt;
        start_seq(len);
        for (int k = 0; k < nb; k++) begin
            if (poke && k == 0) begin
                bus.start = 1'b1;
                bus.len   = 16'd8;
            end
            push_and_send(len, k, base + 64'(k) * 64'h0101010101010101);
            bus.start = 1'b0;
        end
        wait_idle();
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("beat_count", 64'(beat_cnt - b0), 64'(nb));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        int r0;
        bus.start = 1'b0; bus.clear = 1'b0; bus.len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        #3;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_strb", 64'(bus.out_strb), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: 20 bytes -> FF, FF, 0F with truncation on the last block.
        run_seq(20, 64'hA7A6A5A4A3A2A1A0, 1'b0);
        // T2: exact multiple, never truncated.
        run_seq(16, 64'h1122334455667788, 1'b0);

        // T3: zero length, no beats and no input acceptance.
        r0 = in_ready_cnt;
        run_seq(0, 64'h0, 1'b0);
        chk("len0_in_ready", 64'(in_ready_cnt - r0), 64'd0);

        // T4: downstream stalls.
        ready_mode = 2;
        pat_i = 0;
        run_seq(24, 64'hDEADBEEF01234567, 1'b0);
        ready_mode = 0;

        // T5: abort with beat 3 pending.
        d0 = done_cnt;
        start_seq(40);
        for (int k = 0; k < 3; k++) push_and_send(40, k, 64'hF0E0D0C0B0A09080 + 64'(k));
        ready_mode = 1;
        @(posedge clk);
        #1;
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        @(negedge clk);
        chk("clear_out_valid", 64'(bus.out_valid), 64'd0);
        chk("clear_busy", 64'(bus.busy), 64'd0);
        chk("clear_pending", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("clear_no_done", 64'(done_cnt - d0), 64'd0);
        ready_mode = 0;
        run_seq(3, 64'h0102030405060708, 1'b0);

        // T6: start while busy is ignored.
        run_seq(24, 64'h5555AAAA3333CCCC, 1'b1);

        // Asynchronous reset in the middle of RUN.
        ready_mode = 1;
        start_seq(40);
        push_and_send(40, 0, 64'h0F0E0D0C0B0A0908);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h7777777777777777;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("arst_out_data", bus.out_data, 64'd0);
        chk("arst_out_strb", 64'(bus.out_strb), 64'd0);
        chk("arst_out_last", 64'(bus.out_last), 64'd0);
        chk("arst_tr_en", 64'(bus.tr_en), 64'd0);
        bus.in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        run_seq(8, 64'hCAFEF00DCAFEF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
